// File: rtl/mcpu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package mcpu_pkg;

    localparam int unsigned ALU_W_DEF = 4;
    localparam int unsigned IMM_W_DEF = 3;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned OPCODE_W  = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_IF,
        ST_ID,
        ST_EX_R,
        ST_EX_I,
        ST_EX_ADDR,
        ST_MEM_LD,
        ST_MEM_ST,
        ST_WB_ALU,
        ST_WB_LD,
        ST_BR,
        ST_JAL,
        ST_JALR,
        ST_LUI,
        ST_AUIPC,
        ST_HALT
    } state_e;

    localparam logic [ALU_W_DEF-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W_DEF-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_W_DEF-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_W_DEF-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_W_DEF-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_W_DEF-1:0] ALU_SLT  = 4'd5;
    localparam logic [ALU_W_DEF-1:0] ALU_SLTU = 4'd6;
    localparam logic [ALU_W_DEF-1:0] ALU_SLL  = 4'd7;
    localparam logic [ALU_W_DEF-1:0] ALU_SRL  = 4'd8;
    localparam logic [ALU_W_DEF-1:0] ALU_SRA  = 4'd9;

    localparam logic [IMM_W_DEF-1:0] IMM_I = 3'd0;
    localparam logic [IMM_W_DEF-1:0] IMM_S = 3'd1;
    localparam logic [IMM_W_DEF-1:0] IMM_B = 3'd2;
    localparam logic [IMM_W_DEF-1:0] IMM_J = 3'd3;
    localparam logic [IMM_W_DEF-1:0] IMM_U = 3'd4;

    localparam logic [OPCODE_W-1:0] OP_R      = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_I      = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 5'b11000;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 5'b11011;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 5'b11001;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 5'b00101;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] SRC_A_RS1   = 2'd0;
    localparam logic [1:0] SRC_A_PC    = 2'd1;
    localparam logic [1:0] SRC_A_OLDPC = 2'd2;
    localparam logic [1:0] SRC_A_ZERO  = 2'd3;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    // Immediate format implied by the opcode; anything unknown reads as I-type.
    function automatic logic [IMM_W_DEF-1:0] imm_sel_for(input logic [OPCODE_W-1:0] opcode);
        logic [IMM_W_DEF-1:0] sel;
        case (opcode)
            OP_STORE:         sel = IMM_S;
            OP_BRANCH:        sel = IMM_B;
            OP_JAL:           sel = IMM_J;
            OP_LUI, OP_AUIPC: sel = IMM_U;
            default:          sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mcpu_if.sv
// Control-unit to datapath bundle: decoded instruction fields in, strobes and selects out.
interface mcpu_if #(
    parameter int unsigned ALU_CTRL_W = mcpu_pkg::ALU_W_DEF,
    parameter int unsigned IMM_SEL_W  = mcpu_pkg::IMM_W_DEF
);
    logic [mcpu_pkg::OPCODE_W-1:0] OPcode;
    logic [2:0]                    Fun3;
    logic                          Fun7;
    logic                          br_taken;
    logic                          MIO_ready;

    logic                          PC_write;
    logic [1:0]                    PC_src;
    logic                          IR_write;
    logic [IMM_SEL_W-1:0]          ImmSel;
    logic [1:0]                    ALUSrc_A;
    logic [1:0]                    ALUSrc_B;
    logic [ALU_CTRL_W-1:0]         ALU_Control;
    logic [1:0]                    MemtoReg;
    logic                          RegWrite;
    logic                          MemRW;
    logic                          CPU_MIO;
    logic [mcpu_pkg::STATE_W-1:0]  state;
    logic                          illegal;
    logic                          bus_err;

    modport master (
        input  OPcode, Fun3, Fun7, br_taken, MIO_ready,
        output PC_write, PC_src, IR_write, ImmSel, ALUSrc_A, ALUSrc_B,
               ALU_Control, MemtoReg, RegWrite, MemRW, CPU_MIO, state,
               illegal, bus_err
    );

    modport slave (
        output OPcode, Fun3, Fun7, br_taken, MIO_ready,
        input  PC_write, PC_src, IR_write, ImmSel, ALUSrc_A, ALUSrc_B,
               ALU_Control, MemtoReg, RegWrite, MemRW, CPU_MIO, state,
               illegal, bus_err
    );
endinterface

// File: rtl/mcpu_alu_dec.sv
// Fun3/Fun7 to ALU operation for R-type and I-type arithmetic.
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  logic [2:0]           fun3,
    input  logic                 fun7,
    input  logic                 r_type,
    output logic [ALU_W_DEF-1:0] alu_ctrl_c
);

    // Fun7 means SUB only for register ops (addi has no subtract form); it always picks SRA.
    always_comb begin
        alu_ctrl_c = ALU_ADD;
        case (fun3)
            3'b000:  alu_ctrl_c = (r_type && fun7) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ctrl_c = ALU_SLL;
            3'b010:  alu_ctrl_c = ALU_SLT;
            3'b011:  alu_ctrl_c = ALU_SLTU;
            3'b100:  alu_ctrl_c = ALU_XOR;
            3'b101:  alu_ctrl_c = fun7 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_ctrl_c = ALU_OR;
            3'b111:  alu_ctrl_c = ALU_AND;
            default: alu_ctrl_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mcpu_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/write-back with MIO wait states,
// a memory-response timeout and sticky illegal/bus-error flags.
module mcpu_control
    import mcpu_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = ALU_W_DEF,
    parameter int unsigned IMM_SEL_W  = IMM_W_DEF,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic   clk,
    input  logic   rst,
    mcpu_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e                state_q, state_d;
    logic                  run_q;
    logic                  illegal_q, illegal_d;
    logic                  bus_err_q, bus_err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [OPCODE_W-1:0]   op_q;
    logic [2:0]            f3_q;
    logic                  f7_q;
    logic                  mem_state, waiting, timeout_hit;
    logic [ALU_W_DEF-1:0]  dec_alu_c;
    logic [ALU_W_DEF-1:0]  alu_c;
    logic [IMM_W_DEF-1:0]  imm_c;

    mcpu_alu_dec u_alu_dec (
        .fun3       (f3_q),
        .fun7       (f7_q),
        .r_type     (state_q == ST_EX_R),
        .alu_ctrl_c (dec_alu_c)
    );

    // run_q holds every strobe low until the first edge after reset release.
    assign mem_state   = (state_q == ST_IF) || (state_q == ST_MEM_LD) || (state_q == ST_MEM_ST);
    assign waiting     = run_q && mem_state && !bus.MIO_ready;
    assign timeout_hit = waiting && (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1);
    assign cnt_d       = waiting ? cnt_q + CNT_W'(1) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IF;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
            f3_q      <= '0;
            f7_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
            if (state_q == ST_ID) begin
                op_q <= bus.OPcode;
                f3_q <= bus.Fun3;
                f7_q <= bus.Fun7;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        bus.PC_write = 1'b0;
        bus.PC_src   = PC_SRC_ALU;
        bus.IR_write = 1'b0;
        imm_c        = IMM_I;
        bus.ALUSrc_A = SRC_A_RS1;
        bus.ALUSrc_B = SRC_B_RS2;
        alu_c        = ALU_ADD;
        bus.MemtoReg = WB_ALUOUT;
        bus.RegWrite = 1'b0;
        bus.MemRW    = 1'b0;
        bus.CPU_MIO  = 1'b0;

        if (run_q) begin
            case (state_q)
                ST_IF: begin
                    bus.CPU_MIO = 1'b1;
                    if (bus.MIO_ready) begin
                        bus.IR_write = 1'b1;
                        bus.PC_write = 1'b1;
                        bus.ALUSrc_A = SRC_A_PC;
                        bus.ALUSrc_B = SRC_B_FOUR;
                        state_d      = ST_ID;
                    end else if (timeout_hit) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                end
                ST_ID: begin
                    // ALUOut <= OldPC + imm, the branch/jump target
                    bus.ALUSrc_A = SRC_A_OLDPC;
                    bus.ALUSrc_B = SRC_B_IMM;
                    imm_c        = imm_sel_for(bus.OPcode);
                    case (bus.OPcode)
                        OP_R:              state_d = ST_EX_R;
                        OP_I:              state_d = ST_EX_I;
                        OP_LOAD, OP_STORE: state_d = ST_EX_ADDR;
                        OP_BRANCH:         state_d = ST_BR;
                        OP_JAL:            state_d = ST_JAL;
                        OP_JALR:           state_d = ST_JALR;
                        OP_LUI:            state_d = ST_LUI;
                        OP_AUIPC:          state_d = ST_AUIPC;
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = ST_HALT;
                        end
                    endcase
                end
                ST_EX_R: begin
                    alu_c   = dec_alu_c;
                    state_d = ST_WB_ALU;
                end
                ST_EX_I: begin
                    bus.ALUSrc_B = SRC_B_IMM;
                    alu_c        = dec_alu_c;
                    state_d      = ST_WB_ALU;
                end
                ST_EX_ADDR: begin
                    bus.ALUSrc_B = SRC_B_IMM;
                    imm_c        = imm_sel_for(op_q);
                    state_d      = (op_q == OP_STORE) ? ST_MEM_ST : ST_MEM_LD;
                end
                ST_MEM_LD: begin
                    bus.CPU_MIO = 1'b1;
                    if (bus.MIO_ready) begin
                        state_d = ST_WB_LD;
                    end else if (timeout_hit) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                end
                ST_MEM_ST: begin
                    bus.CPU_MIO = 1'b1;
                    bus.MemRW   = 1'b1;
                    if (bus.MIO_ready) begin
                        state_d = ST_IF;
                    end else if (timeout_hit) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                end
                ST_WB_ALU: begin
                    bus.RegWrite = 1'b1;
                    state_d      = ST_IF;
                end
                ST_WB_LD: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = WB_MDR;
                    state_d      = ST_IF;
                end
                ST_BR: begin
                    alu_c        = ALU_SUB;
                    bus.PC_write = bus.br_taken;
                    bus.PC_src   = PC_SRC_ALUOUT;
                    state_d      = ST_IF;
                end
                ST_JAL: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = WB_PC;
                    bus.PC_write = 1'b1;
                    bus.PC_src   = PC_SRC_ALUOUT;
                    state_d      = ST_IF;
                end
                ST_JALR: begin
                    // the ALU forms rs1 + imm here; the PC mux clears bit 0
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = WB_PC;
                    bus.PC_write = 1'b1;
                    bus.PC_src   = PC_SRC_JALR;
                    bus.ALUSrc_B = SRC_B_IMM;
                    state_d      = ST_IF;
                end
                ST_LUI: begin
                    bus.ALUSrc_A = SRC_A_ZERO;
                    bus.ALUSrc_B = SRC_B_IMM;
                    imm_c        = IMM_U;
                    state_d      = ST_WB_ALU;
                end
                ST_AUIPC: begin
                    bus.ALUSrc_A = SRC_A_OLDPC;
                    bus.ALUSrc_B = SRC_B_IMM;
                    imm_c        = IMM_U;
                    state_d      = ST_WB_ALU;
                end
                default: state_d = ST_HALT;
            endcase
        end
    end

    assign bus.ALU_Control = ALU_CTRL_W'(alu_c);
    assign bus.ImmSel      = IMM_SEL_W'(imm_c);
    assign bus.state       = state_q;
    assign bus.illegal     = illegal_q;
    assign bus.bus_err     = bus_err_q;

endmodule

// File: tb/tb_mcpu_control.sv
// Directed bench for mcpu_control: instruction classes, wait states, timeout, illegal opcode, reset.
module tb_mcpu_control;
    import mcpu_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    mcpu_if bus ();

    mcpu_control #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_inst(input logic [4:0] op, input logic [2:0] f3, input logic f7);
        bus.OPcode = op;
        bus.Fun3   = f3;
        bus.Fun7   = f7;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst           = 1'b0;
        bus.br_taken  = 1'b0;
        bus.MIO_ready = 1'b1;
        set_inst(5'b01100, 3'b000, 1'b0);

        // reset state
        #2;
        chk4("rst_state",   bus.state, 4'd0);
        chk1("rst_cpu_mio", bus.CPU_MIO, 1'b0);
        chk1("rst_pc_write", bus.PC_write, 1'b0);
        chk1("rst_illegal", bus.illegal, 1'b0);
        chk1("rst_bus_err", bus.bus_err, 1'b0);
        step();
        rst = 1'b1;
        #1;
        chk1("rel_cpu_mio",  bus.CPU_MIO, 1'b0);
        chk1("rel_ir_write", bus.IR_write, 1'b0);
        chk1("rel_pc_write", bus.PC_write, 1'b0);

        // add x3,x1,x2
        step();
        chk4("add_if_state", bus.state, 4'd0);
        chk1("add_if_mio",   bus.CPU_MIO, 1'b1);
        chk1("add_if_irw",   bus.IR_write, 1'b1);
        chk1("add_if_pcw",   bus.PC_write, 1'b1);
        chk2("add_if_srcb",  bus.ALUSrc_B, 2'd2);
        chk1("add_if_rw",    bus.RegWrite, 1'b0);
        step();
        chk4("add_id_state", bus.state, 4'd1);
        chk2("add_id_srca",  bus.ALUSrc_A, 2'd2);
        chk2("add_id_srcb",  bus.ALUSrc_B, 2'd1);
        chk1("add_id_rw",    bus.RegWrite, 1'b0);
        step();
        chk4("add_ex_state", bus.state, 4'd2);
        chk4("add_ex_alu",   bus.ALU_Control, 4'd0);
        chk1("add_ex_rw",    bus.RegWrite, 1'b0);
        step();
        chk4("add_wb_state", bus.state, 4'd7);
        chk1("add_wb_rw",    bus.RegWrite, 1'b1);
        chk2("add_wb_m2r",   bus.MemtoReg, 2'd0);
        step();
        chk4("add_done_state", bus.state, 4'd0);
        chk1("add_done_rw",    bus.RegWrite, 1'b0);

        // sub: Fun7 selects SUB for R-type
        set_inst(5'b01100, 3'b000, 1'b1);
        step();
        step();
        chk4("sub_ex_alu", bus.ALU_Control, 4'd1);
        step();
        step();

        // srai: Fun7 selects SRA in I-type
        set_inst(5'b00100, 3'b101, 1'b1);
        step();
        step();
        chk4("srai_state",  bus.state, 4'd3);
        chk4("srai_alu",    bus.ALU_Control, 4'd9);
        chk2("srai_srcb",   bus.ALUSrc_B, 2'd1);
        step();
        chk1("srai_wb_rw",  bus.RegWrite, 1'b1);
        step();

        // addi with inst[30]=1 must remain ADD
        set_inst(5'b00100, 3'b000, 1'b1);
        step();
        step();
        chk4("addi_f7_alu", bus.ALU_Control, 4'd0);
        step();
        step();

        // lw with three wait cycles in MEM_LD
        set_inst(5'b00000, 3'b010, 1'b0);
        chk4("lw_c1_state", bus.state, 4'd0);
        step();
        chk4("lw_c2_state", bus.state, 4'd1);
        step();
        chk4("lw_c3_state", bus.state, 4'd4);
        chk3("lw_c3_imm",   bus.ImmSel, 3'd0);
        bus.MIO_ready = 1'b0;
        for (int i = 4; i <= 6; i++) begin
            step();
            chk4($sformatf("lw_c%0d_state", i), bus.state, 4'd5);
            chk1($sformatf("lw_c%0d_mio", i),   bus.CPU_MIO, 1'b1);
            chk1($sformatf("lw_c%0d_rw", i),    bus.MemRW, 1'b0);
        end
        step();
        bus.MIO_ready = 1'b1;
        #1;
        chk4("lw_c7_state", bus.state, 4'd5);
        chk1("lw_c7_mio",   bus.CPU_MIO, 1'b1);
        chk1("lw_c7_rw",    bus.MemRW, 1'b0);
        step();
        chk4("lw_c8_state", bus.state, 4'd8);
        chk1("lw_c8_rw",    bus.RegWrite, 1'b1);
        chk2("lw_c8_m2r",   bus.MemtoReg, 2'd1);
        chk1("lw_c8_mio",   bus.CPU_MIO, 1'b0);
        step();

        // beq taken, then not taken
        set_inst(5'b11000, 3'b000, 1'b0);
        bus.br_taken = 1'b1;
        step();
        chk3("beq_id_imm",   bus.ImmSel, 3'd2);
        step();
        chk4("beqt_state",   bus.state, 4'd9);
        chk1("beqt_pcw",     bus.PC_write, 1'b1);
        chk2("beqt_pcsrc",   bus.PC_src, 2'd1);
        chk4("beqt_alu",     bus.ALU_Control, 4'd1);
        step();
        chk4("beqt_next",    bus.state, 4'd0);
        bus.br_taken = 1'b0;
        step();
        step();
        chk4("beqn_state",   bus.state, 4'd9);
        chk1("beqn_pcw",     bus.PC_write, 1'b0);
        step();
        chk4("beqn_next",    bus.state, 4'd0);

        // jal
        set_inst(5'b11011, 3'b000, 1'b0);
        step();
        chk3("jal_id_imm", bus.ImmSel, 3'd3);
        step();
        chk4("jal_state",  bus.state, 4'd10);
        chk1("jal_rw",     bus.RegWrite, 1'b1);
        chk2("jal_m2r",    bus.MemtoReg, 2'd2);
        chk1("jal_pcw",    bus.PC_write, 1'b1);
        chk2("jal_pcsrc",  bus.PC_src, 2'd1);
        step();

        // jalr
        set_inst(5'b11001, 3'b000, 1'b0);
        step();
        step();
        chk4("jalr_state", bus.state, 4'd11);
        chk2("jalr_pcsrc", bus.PC_src, 2'd2);
        chk1("jalr_rw",    bus.RegWrite, 1'b1);
        chk2("jalr_m2r",   bus.MemtoReg, 2'd2);
        step();
        chk4("jalr_next",  bus.state, 4'd0);

        // lui
        set_inst(5'b01101, 3'b000, 1'b0);
        step();
        chk3("lui_id_imm", bus.ImmSel, 3'd4);
        step();
        chk4("lui_state",  bus.state, 4'd12);
        chk2("lui_srca",   bus.ALUSrc_A, 2'd3);
        chk3("lui_imm",    bus.ImmSel, 3'd4);
        step();
        chk4("lui_wb",     bus.state, 4'd7);
        step();

        // sw stalled in MEM_ST, then asynchronous reset
        set_inst(5'b01000, 3'b010, 1'b0);
        step();
        chk3("sw_id_imm",  bus.ImmSel, 3'd1);
        step();
        chk3("sw_ex_imm",  bus.ImmSel, 3'd1);
        bus.MIO_ready = 1'b0;
        step();
        chk4("sw_mem_state", bus.state, 4'd6);
        chk1("sw_mem_rw",    bus.MemRW, 1'b1);
        chk1("sw_mem_mio",   bus.CPU_MIO, 1'b1);
        rst = 1'b0;
        #1;
        chk1("sw_rst_rw",    bus.MemRW, 1'b0);
        chk1("sw_rst_mio",   bus.CPU_MIO, 1'b0);
        chk4("sw_rst_state", bus.state, 4'd0);
        rst = 1'b1;
        bus.MIO_ready = 1'b1;
        #1;
        chk1("sw_rel_mio",   bus.CPU_MIO, 1'b0);
        step();
        chk4("sw2_if_state", bus.state, 4'd0);
        chk1("sw2_if_irw",   bus.IR_write, 1'b1);
        step();
        step();
        step();
        chk4("sw2_mem_state", bus.state, 4'd6);
        chk1("sw2_mem_rw",    bus.MemRW, 1'b1);
        step();
        chk4("sw2_next",      bus.state, 4'd0);
        chk1("sw2_next_rw",   bus.MemRW, 1'b0);

        // illegal opcode
        set_inst(5'b11111, 3'b000, 1'b0);
        step();
        chk1("ill_id_rw",    bus.RegWrite, 1'b0);
        step();
        chk4("ill_state",    bus.state, 4'd14);
        chk1("ill_flag",     bus.illegal, 1'b1);
        chk1("ill_rw",       bus.RegWrite, 1'b0);
        chk1("ill_mio",      bus.CPU_MIO, 1'b0);
        step();
        chk4("ill_hold",     bus.state, 4'd14);
        chk1("ill_hold_rw",  bus.RegWrite, 1'b0);
        chk1("ill_hold_pcw", bus.PC_write, 1'b0);
        rst = 1'b0;
        #1;
        chk1("ill_rst_flag", bus.illegal, 1'b0);

        // timeout: MIO_ready stuck low in IF
        set_inst(5'b00100, 3'b000, 1'b0);
        bus.MIO_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk1("to_w1_mio",  bus.CPU_MIO, 1'b1);
        chk1("to_w1_irw",  bus.IR_write, 1'b0);
        step();
        step();
        step();
        chk4("to_w4_state", bus.state, 4'd0);
        chk1("to_w4_err",   bus.bus_err, 1'b0);
        step();
        chk4("to_halt_state", bus.state, 4'd14);
        chk1("to_halt_err",   bus.bus_err, 1'b1);
        chk1("to_halt_mio",   bus.CPU_MIO, 1'b0);
        bus.MIO_ready = 1'b1;
        step();
        chk4("to_hold_state", bus.state, 4'd14);
        chk1("to_hold_mio",   bus.CPU_MIO, 1'b0);
        chk1("to_hold_irw",   bus.IR_write, 1'b0);
        rst = 1'b0;
        #1;
        chk1("to_rst_err",    bus.bus_err, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk4("to_after_state", bus.state, 4'd0);
        chk1("to_after_irw",   bus.IR_write, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
